switch_port_rx: RTL

- Ingress stage of one port of the 4-port switch. Sits directly downstream of the port_if packet driver and upstream of the crossbar arbiter.
- Delimits packets on the port, validates the header against the switch addressing rules, and discards illegal packets.
- Buffers legal packets in a tagged byte FIFO, drives suspend_ip backpressure to the driver, and presents stored packets to the crossbar with a valid/ready handshake.

---
 rtl/switch_port_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/switch_port_rx.sv
// Ingress stage for one switch port: header check, skid + tagged byte FIFO, registered crossbar output.
// Define SWITCH_RX_STATS_EN to build the drop/truncate counters; otherwise both outputs read 0.
// state   | meaning
// IDLE    | waiting for a header byte
// ACCEPT  | storing a legal packet through the skid register
// DISCARD | ignoring bytes until the gap between packets
module switch_port_rx #(
    parameter int PORT_ID = 0,
    parameter int DEPTH   = 64,
    parameter int MAX_PKT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_ip,
    input  logic [7:0]       data_ip,
    output logic             suspend_ip,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [7:0]       op_data,
    output logic             op_sop,
    output logic             op_eop,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] trunc_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MAX_PKT + 1);
    localparam logic [3:0] SRC_ID = 4'(1 << PORT_ID);
    localparam logic [AW:0] SUSP_LVL = (AW+1)'(DEPTH - MAX_PKT - 2);

    typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_skid_data;
    logic          r_skid_sop;
    logic [LW-1:0] r_len;
    logic          r_rst_d;
    logic [9:0]    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr;
    logic          r_op_valid, r_op_sop, r_op_eop, r_suspend;
    logic [7:0]    r_op_data;
    logic [AW:0]   w_count;
    logic          w_full, w_empty, w_wr_req, w_wr_eop, w_wr_en, w_rd_en, w_load_skid, w_hdr_ok;

    assign w_hdr_ok = (data_ip[7:4] == SRC_ID) &&
                      ((data_ip[3:0] == 4'hf) ||
                       ((data_ip[3:0] != 4'h0) && ((data_ip[7:4] & data_ip[3:0]) == 4'h0)));

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == (AW+1)'(DEPTH));
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_wr_en = w_wr_req && !w_full;
    assign w_rd_en = !w_empty && (!r_op_valid || op_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rst_d <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_rst_d <= 1'b0;
        end
    end

    // A byte seen in IDLE right after reset is the tail of a cut packet, not a header.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_req    = 1'b0;
        w_wr_eop    = 1'b0;
        w_load_skid = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_ip) begin
                    if (r_rst_d) begin
                        w_state_nxt = DISCARD;
                    end else if (w_hdr_ok) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ACCEPT;
                    end else begin
                        w_state_nxt = DISCARD;
                    end
                end
            end
            ACCEPT: begin
                w_wr_req = 1'b1;
                if (!valid_ip) begin
                    w_wr_eop    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_len == LW'(MAX_PKT)) begin
                    w_wr_eop    = 1'b1;
                    w_state_nxt = DISCARD;
                end else begin
                    w_load_skid = 1'b1;
                end
            end
            DISCARD: begin
                if (!valid_ip) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_skid_data <= 8'h00;
            r_skid_sop  <= 1'b0;
            r_len       <= '0;
        end else if (w_load_skid) begin
            r_skid_data <= data_ip;
            r_skid_sop  <= (r_state == IDLE);
            r_len       <= (r_state == IDLE) ? LW'(1) : r_len + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {r_skid_sop, w_wr_eop, r_skid_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_suspend  <= 1'b0;
            r_op_valid <= 1'b0;
            r_op_sop   <= 1'b0;
            r_op_eop   <= 1'b0;
            r_op_data  <= 8'h00;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_suspend <= (w_count >= SUSP_LVL);
            if (w_rd_en) begin
                {r_op_sop, r_op_eop, r_op_data} <= r_mem[r_rd_ptr[AW-1:0]];
                r_op_valid <= 1'b1;
            end else if (op_ready) begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign suspend_ip = r_suspend;
    assign op_valid   = r_op_valid;
    assign op_data    = r_op_data;
    assign op_sop     = r_op_sop;
    assign op_eop     = r_op_eop;

`ifdef SWITCH_RX_STATS_EN
    logic [CNT_W-1:0] r_drop_cnt, r_trunc_cnt;
    logic             w_drop_inc, w_trunc_inc;

    assign w_drop_inc  = (r_state == IDLE) && valid_ip && !r_rst_d && !w_hdr_ok;
    assign w_trunc_inc = (r_state == ACCEPT) && valid_ip && (r_len == LW'(MAX_PKT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt  <= '0;
            r_trunc_cnt <= '0;
        end else begin
            if (w_drop_inc && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_trunc_inc && (r_trunc_cnt != '1)) r_trunc_cnt <= r_trunc_cnt + 1'b1;
        end
    end

    assign drop_cnt  = r_drop_cnt;
    assign trunc_cnt = r_trunc_cnt;
`else
    assign drop_cnt  = '0;
    assign trunc_cnt = '0;
`endif
endmodule
